// File: rtl/operand_entry_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry_ctrl_pkg
//  Description : Shared encodings for the calculator operand-entry front end:
//                controller states, display/operand codes, opcodes, button
//                bit positions and the per-digit edit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_entry_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTER_A   = 3'd1,
        ST_ENTER_B   = 3'd2,
        ST_SELECT_OP = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_SHOW      = 3'd6
    } state_t;

    // Single action chosen per cycle after priority resolution
    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_CENTER = 3'd1,
        ACT_UP     = 3'd2,
        ACT_DOWN   = 3'd3,
        ACT_LEFT   = 3'd4,
        ACT_RIGHT  = 3'd5
    } act_t;

    // display_mode codes
    localparam logic [1:0] MODE_BLANK   = 2'b00;
    localparam logic [1:0] MODE_OPERAND = 2'b01;
    localparam logic [1:0] MODE_RESULT  = 2'b10;

    // chosen_operand codes
    localparam logic [1:0] OPERAND_NONE = 2'b00;
    localparam logic [1:0] OPERAND_A    = 2'b01;
    localparam logic [1:0] OPERAND_B    = 2'b10;

    // Opcodes
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Bit positions of the buttons inside the packed button vector
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_CENTER = 4;
    localparam int BTN_COUNT  = 5;

    // Step one hex digit up or down modulo 16; neighbouring digits untouched
    function automatic logic [15:0] nibble_step(input logic [15:0] value,
                                                input logic [1:0]  idx,
                                                input logic        inc);
        logic [15:0] r_val;
        logic [3:0]  w_nib;
        r_val = value;
        w_nib = value[4*idx +: 4];
        w_nib = inc ? (w_nib + 4'd1) : (w_nib - 4'd1);
        r_val[4*idx +: 4] = w_nib;
        return r_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge_sync
//  Description : Per-bit 2-flop synchronizer followed by a rising-edge
//                detector; a held input yields a single one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_pulse
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    // Synchronize the raw buttons and keep the previous synchronized value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry_ctrl
//  Description : Push-button hex entry of two 16-bit operands and an opcode,
//                ALU valid/ready + done handshake with timeout, and result
//                latching for the 7-segment display stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_entry_ctrl
    import operand_entry_ctrl_pkg::*;
#(
    parameter int          OP_COUNT       = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] ERR_PATTERN    = 16'hEEEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    input  logic        alu_ready,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        alu_valid,
    output logic [1:0]  op_code,
    output logic [1:0]  display_mode,
    output logic [1:0]  chosen_operand,
    output logic [15:0] operandA,
    output logic [15:0] operandB,
    output logic [15:0] result,
    output logic [1:0]  cursor,
    output logic        error
);

    localparam logic [9:0] c_TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] c_OP_LAST      = 2'(OP_COUNT - 1);

    logic [BTN_COUNT-1:0] w_btn_raw;
    logic [BTN_COUNT-1:0] w_press;
    act_t                 w_act;

    state_t      r_state;
    logic        r_alu_valid;
    logic [1:0]  r_op_code;
    logic [1:0]  r_display_mode;
    logic [1:0]  r_chosen;
    logic [15:0] r_operand_a;
    logic [15:0] r_operand_b;
    logic [15:0] r_result;
    logic [1:0]  r_cursor;
    logic        r_error;
    logic [9:0]  r_timeout_cnt;

    assign w_btn_raw[BTN_RIGHT]  = btn_right;
    assign w_btn_raw[BTN_LEFT]   = btn_left;
    assign w_btn_raw[BTN_DOWN]   = btn_down;
    assign w_btn_raw[BTN_UP]     = btn_up;
    assign w_btn_raw[BTN_CENTER] = btn_center;

    btn_edge_sync #(
        .WIDTH (BTN_COUNT)
    ) u_btn_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (w_btn_raw),
        .o_pulse (w_press)
    );

    // Resolve simultaneous presses to a single action: center > up > down > left > right
    always_comb begin
        w_act = ACT_NONE;
        if (w_press[BTN_CENTER])     w_act = ACT_CENTER;
        else if (w_press[BTN_UP])    w_act = ACT_UP;
        else if (w_press[BTN_DOWN])  w_act = ACT_DOWN;
        else if (w_press[BTN_LEFT])  w_act = ACT_LEFT;
        else if (w_press[BTN_RIGHT]) w_act = ACT_RIGHT;
    end

    // Entry/handshake state machine; every output is a register updated here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_alu_valid    <= 1'b0;
            r_op_code      <= OP_ADD;
            r_display_mode <= MODE_BLANK;
            r_chosen       <= OPERAND_NONE;
            r_operand_a    <= '0;
            r_operand_b    <= '0;
            r_result       <= '0;
            r_cursor       <= '0;
            r_error        <= 1'b0;
            r_timeout_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_act == ACT_CENTER) begin
                        r_state        <= ST_ENTER_A;
                        r_display_mode <= MODE_OPERAND;
                        r_chosen       <= OPERAND_A;
                        r_cursor       <= '0;
                    end
                end

                ST_ENTER_A, ST_ENTER_B: begin
                    case (w_act)
                        ACT_CENTER: begin
                            if (r_state == ST_ENTER_A) begin
                                r_state  <= ST_ENTER_B;
                                r_chosen <= OPERAND_B;
                                r_cursor <= '0;
                            end else begin
                                r_state        <= ST_SELECT_OP;
                                r_display_mode <= MODE_BLANK;
                                r_chosen       <= OPERAND_NONE;
                            end
                        end
                        ACT_UP, ACT_DOWN: begin
                            if (r_state == ST_ENTER_A)
                                r_operand_a <= nibble_step(r_operand_a, r_cursor, w_act == ACT_UP);
                            else
                                r_operand_b <= nibble_step(r_operand_b, r_cursor, w_act == ACT_UP);
                        end
                        ACT_LEFT:  r_cursor <= r_cursor + 2'd1;
                        ACT_RIGHT: r_cursor <= r_cursor - 2'd1;
                        default: ;
                    endcase
                end

                ST_SELECT_OP: begin
                    case (w_act)
                        ACT_CENTER: begin
                            r_state     <= ST_ISSUE;
                            r_alu_valid <= 1'b1;
                        end
                        ACT_UP:   r_op_code <= (r_op_code == c_OP_LAST) ? 2'd0 : r_op_code + 2'd1;
                        ACT_DOWN: r_op_code <= (r_op_code == 2'd0) ? c_OP_LAST : r_op_code - 2'd1;
                        default: ;
                    endcase
                end

                ST_ISSUE: begin
                    // Request held until the ALU accepts it; done here is ignored
                    if (alu_ready) begin
                        r_state       <= ST_WAIT_DONE;
                        r_alu_valid   <= 1'b0;
                        r_timeout_cnt <= '0;
                    end
                end

                ST_WAIT_DONE: begin
                    // Done takes precedence over a coincident timeout
                    if (alu_done) begin
                        r_state        <= ST_SHOW;
                        r_result       <= alu_result;
                        r_error        <= 1'b0;
                        r_display_mode <= MODE_RESULT;
                    end else if (r_timeout_cnt == c_TIMEOUT_LAST) begin
                        r_state        <= ST_SHOW;
                        r_result       <= ERR_PATTERN;
                        r_error        <= 1'b1;
                        r_display_mode <= MODE_RESULT;
                    end else if (r_timeout_cnt != '1) begin
                        r_timeout_cnt <= r_timeout_cnt + 10'd1;
                    end
                end

                ST_SHOW: begin
                    if (w_act == ACT_CENTER) begin
                        r_state        <= ST_ENTER_A;
                        r_display_mode <= MODE_OPERAND;
                        r_chosen       <= OPERAND_A;
                        r_cursor       <= '0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_valid      = r_alu_valid;
    assign op_code        = r_op_code;
    assign display_mode   = r_display_mode;
    assign chosen_operand = r_chosen;
    assign operandA       = r_operand_a;
    assign operandB       = r_operand_b;
    assign result         = r_result;
    assign cursor         = r_cursor;
    assign error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_entry_ctrl
//  Description : Directed self-checking bench for operand_entry_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_center;
    logic        alu_ready;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_valid;
    logic [1:0]  op_code;
    logic [1:0]  display_mode;
    logic [1:0]  chosen_operand;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic [15:0] result;
    logic [1:0]  cursor;
    logic        error;

    int checks;
    int errors;

    // Button masks: {center, up, down, left, right}
    localparam logic [4:0] c_CENTER = 5'b10000;
    localparam logic [4:0] c_UP     = 5'b01000;
    localparam logic [4:0] c_DOWN   = 5'b00100;
    localparam logic [4:0] c_LEFT   = 5'b00010;
    localparam logic [4:0] c_RIGHT  = 5'b00001;

    operand_entry_ctrl #(
        .OP_COUNT       (4),
        .TIMEOUT_CYCLES (1024),
        .ERR_PATTERN    (16'hEEEE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_center     (btn_center),
        .alu_ready      (alu_ready),
        .alu_done       (alu_done),
        .alu_result     (alu_result),
        .alu_valid      (alu_valid),
        .op_code        (op_code),
        .display_mode   (display_mode),
        .chosen_operand (chosen_operand),
        .operandA       (operandA),
        .operandB       (operandB),
        .result         (result),
        .cursor         (cursor),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no checking inside)
    task automatic set_btns(input logic [4:0] m);
        {btn_center, btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        set_btns(m);
        @(negedge clk);
        set_btns(5'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic press_n(input logic [4:0] m, input int n);
        for (int i = 0; i < n; i++) press(m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({alu_valid, op_code, display_mode, chosen_operand, operandA, operandB, result, cursor, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b op=%0d mode=%b ch=%b A=%h B=%h res=%h cur=%0d err=%b, want all zero",
                     alu_valid, op_code, display_mode, chosen_operand, operandA, operandB, result, cursor, error);
        end
        // Latency: raw press sampled at P1, output changes at P3
        @(negedge clk);
        btn_center = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (display_mode !== 2'b00) begin
            errors++;
            $display("FAIL latency_early: display_mode=%b want 00", display_mode);
        end
        @(negedge clk);
        checks++;
        if (display_mode !== 2'b01 || chosen_operand !== 2'b01 || operandA !== 16'h0000 || cursor !== 2'd0) begin
            errors++;
            $display("FAIL enter_a: mode=%b ch=%b A=%h cur=%0d want 01 01 0000 0", display_mode, chosen_operand, operandA, cursor);
        end
        // Keep holding: no further action
        repeat (10) @(negedge clk);
        btn_center = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (chosen_operand !== 2'b01) begin
            errors++;
            $display("FAIL hold_center: chosen_operand=%b want 01", chosen_operand);
        end
    endtask

    task automatic test_digit_edit();
        press(c_DOWN);
        checks++;
        if (operandA !== 16'h000F) begin
            errors++;
            $display("FAIL nibble_underflow: operandA=%h want 000F", operandA);
        end
        press(c_RIGHT);
        checks++;
        if (cursor !== 2'd3) begin
            errors++;
            $display("FAIL cursor_wrap_right: cursor=%0d want 3", cursor);
        end
        press_n(c_RIGHT, 3);
        checks++;
        if (cursor !== 2'd0) begin
            errors++;
            $display("FAIL cursor_back_to_0: cursor=%0d want 0", cursor);
        end
        press(c_UP);
        checks++;
        if (operandA !== 16'h0000) begin
            errors++;
            $display("FAIL nibble_overflow: operandA=%h want 0000", operandA);
        end
        press_n(c_UP, 17);
        press(c_LEFT);
        press_n(c_UP, 2);
        checks++;
        if (operandA !== 16'h0021 || cursor !== 2'd1) begin
            errors++;
            $display("FAIL up17_left_up2: operandA=%h cursor=%0d want 0021 1", operandA, cursor);
        end
        press_n(c_LEFT, 3);
        checks++;
        if (cursor !== 2'd0) begin
            errors++;
            $display("FAIL cursor_wrap_left: cursor=%0d want 0", cursor);
        end
        press(c_LEFT);
    endtask

    task automatic test_priority_hold();
        // cursor 1, A=0021: up+left together -> increment only
        press(c_UP | c_LEFT);
        checks++;
        if (operandA !== 16'h0031 || cursor !== 2'd1) begin
            errors++;
            $display("FAIL up_left_same_cycle: operandA=%h cursor=%0d want 0031 1", operandA, cursor);
        end
        @(negedge clk);
        btn_up = 1'b1;
        repeat (50) @(negedge clk);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (operandA !== 16'h0041) begin
            errors++;
            $display("FAIL hold_up_single: operandA=%h want 0041", operandA);
        end
        // center beats up: leave ENTER_A with operandA untouched
        press(c_CENTER | c_UP);
        checks++;
        if (operandA !== 16'h0041 || chosen_operand !== 2'b10 || cursor !== 2'd0 || operandB !== 16'h0000) begin
            errors++;
            $display("FAIL center_over_up: A=%h ch=%b cur=%0d B=%h want 0041 10 0 0000", operandA, chosen_operand, cursor, operandB);
        end
    endtask

    task automatic test_operation();
        do_reset();
        press(c_CENTER);
        press_n(c_UP, 2);
        press(c_LEFT);
        press(c_UP);
        press(c_CENTER);
        checks++;
        if (operandA !== 16'h0012 || chosen_operand !== 2'b10 || cursor !== 2'd0) begin
            errors++;
            $display("FAIL enter_b: A=%h ch=%b cur=%0d want 0012 10 0", operandA, chosen_operand, cursor);
        end
        press_n(c_UP, 3);
        press(c_CENTER);
        checks++;
        if (operandB !== 16'h0003 || display_mode !== 2'b00 || chosen_operand !== 2'b00) begin
            errors++;
            $display("FAIL select_op_entry: B=%h mode=%b ch=%b want 0003 00 00", operandB, display_mode, chosen_operand);
        end
        press(c_DOWN);
        checks++;
        if (op_code !== 2'd3) begin
            errors++;
            $display("FAIL op_wrap_down: op_code=%0d want 3", op_code);
        end
        press(c_UP);
        checks++;
        if (op_code !== 2'd0) begin
            errors++;
            $display("FAIL op_wrap_up: op_code=%0d want 0", op_code);
        end
        press(c_UP);
        checks++;
        if (op_code !== 2'd1) begin
            errors++;
            $display("FAIL op_select: op_code=%0d want 1", op_code);
        end
        press(c_CENTER);
        // ready low for 5 cycles; a stray done in ISSUE must be ignored
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (alu_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid_held[%0d]: alu_valid=%b want 1", i, alu_valid);
            end
            if (i == 1) begin
                alu_done   = 1'b1;
                alu_result = 16'h1234;
            end else begin
                alu_done   = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (alu_valid !== 1'b1 || display_mode !== 2'b00) begin
            errors++;
            $display("FAIL done_in_issue_ignored: valid=%b mode=%b want 1 00", alu_valid, display_mode);
        end
        alu_ready = 1'b1;
        @(negedge clk);
        alu_ready = 1'b0;
        checks++;
        if (alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: alu_valid=%b want 0", alu_valid);
        end
        repeat (3) @(negedge clk);
        alu_done   = 1'b1;
        alu_result = 16'h000F;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        checks++;
        if (display_mode !== 2'b10 || result !== 16'h000F || error !== 1'b0 ||
            operandA !== 16'h0012 || operandB !== 16'h0003 || op_code !== 2'd1) begin
            errors++;
            $display("FAIL show_result: mode=%b res=%h err=%b A=%h B=%h op=%0d want 10 000F 0 0012 0003 1",
                     display_mode, result, error, operandA, operandB, op_code);
        end
    endtask

    task automatic test_timeout();
        press(c_CENTER);
        checks++;
        if (display_mode !== 2'b01 || chosen_operand !== 2'b01 || cursor !== 2'd0 ||
            operandA !== 16'h0012 || result !== 16'h000F) begin
            errors++;
            $display("FAIL show_to_enter_a: mode=%b ch=%b cur=%0d A=%h res=%h want 01 01 0 0012 000F",
                     display_mode, chosen_operand, cursor, operandA, result);
        end
        press_n(c_CENTER, 3);
        alu_ready = 1'b1;
        @(negedge clk);
        alu_ready = 1'b0;
        repeat (10) @(negedge clk);
        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        repeat (1012) @(negedge clk);
        checks++;
        if (error !== 1'b0 || display_mode !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early: err=%b mode=%b want 0 00", error, display_mode);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || result !== 16'hEEEE || display_mode !== 2'b10) begin
            errors++;
            $display("FAIL timeout: err=%b res=%h mode=%b want 1 EEEE 10", error, result, display_mode);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (op_code !== 2'd1 || operandA !== 16'h0012) begin
            errors++;
            $display("FAIL no_deferred_press: op=%0d A=%h want 1 0012", op_code, operandA);
        end
    endtask

    task automatic test_async_reset();
        // Reset during ISSUE drops alu_valid without a clock edge
        press(c_CENTER);
        press(c_UP);
        press_n(c_CENTER, 3);
        checks++;
        if (alu_valid !== 1'b1) begin
            errors++;
            $display("FAIL issue_reached: alu_valid=%b want 1", alu_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({alu_valid, op_code, display_mode, chosen_operand, operandA, operandB, result, cursor, error} !== '0) begin
            errors++;
            $display("FAIL async_reset_issue: valid=%b op=%0d mode=%b A=%h res=%h err=%b want all zero",
                     alu_valid, op_code, display_mode, operandA, result, error);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // Reset during WAIT_DONE
        press(c_CENTER);
        press(c_UP);
        press_n(c_CENTER, 3);
        alu_ready = 1'b1;
        @(negedge clk);
        alu_ready = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({alu_valid, op_code, display_mode, chosen_operand, operandA, operandB, result, cursor, error} !== '0) begin
            errors++;
            $display("FAIL async_reset_wait: valid=%b mode=%b A=%h res=%h err=%b want all zero",
                     alu_valid, display_mode, operandA, result, error);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        set_btns(5'b0);
        alu_ready  = 1'b0;
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_digit_edit();
        test_priority_hold();
        test_operation();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
